// File: rtl/pll_phase_meter.sv
// pll_phase_meter
//   Measures an asynchronous reference against the recovered PLL output,
//   both sampled on clk_50. Reports the mean reference period and the mean
//   lag from reference rise to PLL rise over 2^AVG_LOG2 periods, a no-signal
//   flag when the reference stops and a lock flag when the lag is stable.
//
// Ports
//   clk_50      in   system clock
//   rst         in   synchronous reset, active-high
//   ref_in      in   reference input, asynchronous
//   pll_in      in   PLL output under test, asynchronous
//   period      out  averaged reference period, clk_50 cycles
//   phase       out  averaged ref-rise to pll-rise lag, clk_50 cycles
//   meas_valid  out  one-cycle pulse when period/phase update
//   nosig       out  reference absent
//   lock        out  phase stable between consecutive results
//   phase_deg   out  phase in degrees 0..359 (0 when divider not built)
//   deg_valid   out  one-cycle pulse when phase_deg updates
//
// Build option
//   PLL_PHASE_METER_DEG_EN : include the serial divider producing phase_deg.
//   Without it phase_deg and deg_valid are tied low.

module pll_phase_meter #(
    parameter int CNT_W    = 16,
    parameter int AVG_LOG2 = 2,
    parameter int TIMEOUT  = 5000,
    parameter int LOCK_TOL = 4
) (
    input  logic             clk_50,
    input  logic             rst,
    input  logic             ref_in,
    input  logic             pll_in,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] phase,
    output logic             meas_valid,
    output logic             nosig,
    output logic             lock,
    output logic [8:0]       phase_deg,
    output logic             deg_valid
);

    localparam int ACC_W  = CNT_W + AVG_LOG2;
    localparam int NCNT_W = AVG_LOG2 + 1;
    localparam int TMO_W  = $clog2(TIMEOUT + 1);

    localparam logic [NCNT_W-1:0] N_LAST   = NCNT_W'((1 << AVG_LOG2) - 1);
    localparam logic [TMO_W-1:0]  TMO_LAST = TMO_W'(TIMEOUT - 1);

    typedef enum logic {
        S_IDLE,
        S_RUN
    } state_t;

    state_t state;
    state_t state_nxt;

    // [0] first sync flop, [1] second sync flop, [2] previous synced value
    logic [2:0] ref_sh;
    logic [2:0] pll_sh;
    logic       ref_edge;
    logic       pll_edge;

    logic [CNT_W-1:0]  per_cnt;
    logic [CNT_W-1:0]  ph_smp;
    logic              ph_done;
    logic [ACC_W-1:0]  acc_p;
    logic [ACC_W-1:0]  acc_ph;
    logic [NCNT_W-1:0] n_cnt;
    logic              miss;
    logic              have_prev;
    logic [TMO_W-1:0]  tmo_cnt;

    logic              take;
    logic              win_done;
    logic              tmo_hit;
    logic [CNT_W-1:0]  ph_sample;
    logic [CNT_W-1:0]  per_inc;
    logic [ACC_W-1:0]  sum_p;
    logic [ACC_W-1:0]  sum_ph;
    logic [CNT_W-1:0]  new_period;
    logic [CNT_W-1:0]  new_phase;
    logic [CNT_W-1:0]  ph_delta;
    logic              win_miss;
    logic              stable;

    // ------------------------------------------------------------------
    // Input synchronisers and rising-edge detect
    // ------------------------------------------------------------------
    always_ff @(posedge clk_50) begin
        if (rst) begin
            ref_sh <= '0;
            pll_sh <= '0;
        end else begin
            ref_sh <= {ref_sh[1:0], ref_in};
            pll_sh <= {pll_sh[1:0], pll_in};
        end
    end

    assign ref_edge = ref_sh[1] & ~ref_sh[2];
    assign pll_edge = pll_sh[1] & ~pll_sh[2];

    // ------------------------------------------------------------------
    // Measurement FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk_50) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        take      = 1'b0;
        win_done  = 1'b0;
        // A ref edge restarts the timeout, so it can never coincide with expiry
        tmo_hit   = !nosig && !ref_edge && (tmo_cnt == TMO_LAST);
        case (state)
            S_IDLE: begin
                if (ref_edge) begin
                    state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (tmo_hit) begin
                    state_nxt = S_IDLE;
                end else if (ref_edge) begin
                    take     = 1'b1;
                    win_done = (n_cnt == N_LAST);
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Sample and result arithmetic
    // ------------------------------------------------------------------
    always_comb begin
        // The phase counter would always equal the period counter, so the
        // phase sample is simply per_cnt frozen at the first pll edge. With
        // no pll edge in the period the sample falls back to the period.
        ph_sample  = ph_done ? ph_smp : per_cnt;
        per_inc    = (per_cnt == '1) ? per_cnt : per_cnt + CNT_W'(1);
        sum_p      = acc_p  + ACC_W'(per_cnt);
        sum_ph     = acc_ph + ACC_W'(ph_sample);
        new_period = sum_p[ACC_W-1:AVG_LOG2];
        new_phase  = sum_ph[ACC_W-1:AVG_LOG2];
        ph_delta   = (new_phase >= phase) ? (new_phase - phase) : (phase - new_phase);
        win_miss   = miss | ~ph_done;
        stable     = have_prev && (ph_delta <= CNT_W'(LOCK_TOL)) && !win_miss;
    end

    always_ff @(posedge clk_50) begin
        if (rst) begin
            period     <= '0;
            phase      <= '0;
            meas_valid <= 1'b0;
            nosig      <= 1'b1;
            lock       <= 1'b0;
            per_cnt    <= '0;
            ph_smp     <= '0;
            ph_done    <= 1'b0;
            acc_p      <= '0;
            acc_ph     <= '0;
            n_cnt      <= '0;
            miss       <= 1'b0;
            have_prev  <= 1'b0;
            tmo_cnt    <= '0;
        end else begin
            meas_valid <= 1'b0;

            // Timeout: cycles since the last ref edge, frozen once nosig is set
            if (ref_edge) begin
                tmo_cnt <= '0;
                nosig   <= 1'b0;
            end else if (tmo_hit) begin
                nosig <= 1'b1;
                lock  <= 1'b0;
            end else if (!nosig) begin
                tmo_cnt <= tmo_cnt + TMO_W'(1);
            end

            // Period counter and first-pll-edge capture
            if (ref_edge) begin
                per_cnt <= CNT_W'(1);
                ph_done <= pll_edge;
                ph_smp  <= '0;
            end else if (state == S_RUN && !tmo_hit) begin
                per_cnt <= per_inc;
                if (pll_edge && !ph_done) begin
                    ph_done <= 1'b1;
                    ph_smp  <= per_cnt;
                end
            end else begin
                per_cnt <= '0;
                ph_done <= 1'b0;
                ph_smp  <= '0;
            end

            // Window accumulation and result publication
            if (take) begin
                if (win_done) begin
                    period     <= new_period;
                    phase      <= new_phase;
                    meas_valid <= 1'b1;
                    lock       <= stable;
                    have_prev  <= 1'b1;
                    acc_p      <= '0;
                    acc_ph     <= '0;
                    n_cnt      <= '0;
                    miss       <= 1'b0;
                end else begin
                    acc_p  <= sum_p;
                    acc_ph <= sum_ph;
                    n_cnt  <= n_cnt + NCNT_W'(1);
                    miss   <= win_miss;
                end
            end else if (state_nxt == S_IDLE) begin
                acc_p     <= '0;
                acc_ph    <= '0;
                n_cnt     <= '0;
                miss      <= 1'b0;
                have_prev <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Optional degrees conversion: phase*360/period, restoring division
    // ------------------------------------------------------------------
`ifdef PLL_PHASE_METER_DEG_EN
    localparam int Q_W  = CNT_W + 9;
    localparam int DC_W = $clog2(Q_W);

    localparam logic [DC_W-1:0] DC_LAST = DC_W'(Q_W - 1);

    // div_q starts as the dividend and shifts left; quotient bits enter at
    // the bottom, so after Q_W steps it holds the full quotient.
    logic [Q_W-1:0]   div_q;
    logic [CNT_W-1:0] div_rem;
    logic [CNT_W-1:0] div_d;
    logic [DC_W-1:0]  div_cnt;
    logic             div_busy;
    logic             div_cap;
    logic [CNT_W:0]   rem_sh;
    logic [CNT_W:0]   rem_sub;
    logic             rem_ge;

    always_comb begin
        rem_sh  = {div_rem, div_q[Q_W-1]};
        rem_ge  = (rem_sh >= {1'b0, div_d});
        rem_sub = rem_ge ? (rem_sh - {1'b0, div_d}) : rem_sh;
    end

    always_ff @(posedge clk_50) begin
        if (rst) begin
            div_q     <= '0;
            div_rem   <= '0;
            div_d     <= '0;
            div_cnt   <= '0;
            div_busy  <= 1'b0;
            div_cap   <= 1'b0;
            phase_deg <= '0;
            deg_valid <= 1'b0;
        end else begin
            deg_valid <= 1'b0;
            if (meas_valid) begin
                // A new result always restarts, dropping any division in flight
                div_q    <= Q_W'(phase) * Q_W'(360);
                div_rem  <= '0;
                div_d    <= period;
                div_cnt  <= '0;
                div_busy <= 1'b1;
                div_cap  <= (phase >= period);
            end else if (div_busy) begin
                div_q   <= {div_q[Q_W-2:0], rem_ge};
                div_rem <= rem_sub[CNT_W-1:0];
                div_cnt <= div_cnt + DC_W'(1);
                if (div_cnt == DC_LAST) begin
                    div_busy  <= 1'b0;
                    deg_valid <= 1'b1;
                    phase_deg <= div_cap ? 9'd359 : {div_q[7:0], rem_ge};
                end
            end
        end
    end
`else
    assign phase_deg = '0;
    assign deg_valid = 1'b0;
`endif

endmodule

// File: tb/tb_pll_phase_meter.sv
// Self-checking bench for pll_phase_meter. Reference and PLL waveforms are
// driven period by period; a model computes each window's expected result
// from the driven rise times and PLL offsets.
module tb_pll_phase_meter;

    localparam int CNT_W   = 16;
    localparam int TIMEOUT = 5000;
    localparam int TOL     = 4;
    localparam int NAVG    = 4;

    logic             clk_50 = 1'b0;
    logic             rst    = 1'b1;
    logic             ref_in = 1'b0;
    logic             pll_in = 1'b0;
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] phase;
    logic             meas_valid;
    logic             nosig;
    logic             lock;
    logic [8:0]       phase_deg;
    logic             deg_valid;

    pll_phase_meter #(
        .CNT_W   (CNT_W),
        .AVG_LOG2(2),
        .TIMEOUT (TIMEOUT),
        .LOCK_TOL(TOL)
    ) dut (
        .clk_50    (clk_50),
        .rst       (rst),
        .ref_in    (ref_in),
        .pll_in    (pll_in),
        .period    (period),
        .phase     (phase),
        .meas_valid(meas_valid),
        .nosig     (nosig),
        .lock      (lock),
        .phase_deg (phase_deg),
        .deg_valid (deg_valid)
    );

    always #10 clk_50 = ~clk_50;

    int unsigned cyc = 0;
    always @(posedge clk_50) cyc <= cyc + 1;

    typedef struct packed {
        int          period;
        int          phase;
        bit          lock;
        int unsigned cyc;
    } res_t;

    res_t got_q[$];
    res_t exp_q[$];
    int   deg_q[$];
    int   exp_deg_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    bit   g_ns_pre;
    bit   g_ns_post;

    // Record every output pulse; tests compare these against the model.
    always @(negedge clk_50) begin
        res_t r;
        if (meas_valid) begin
            r.period = int'(period);
            r.phase  = int'(phase);
            r.lock   = lock;
            r.cyc    = cyc;
            got_q.push_back(r);
        end
        if (deg_valid) deg_q.push_back(int'(phase_deg));
    end

    // ---------------- reference model ----------------
    bit          m_run;
    int unsigned m_last_rise;
    int          m_pend_ph;
    bit          m_pend_present;
    int          m_sum_p, m_sum_ph, m_n;
    bit          m_miss;
    bit          m_have_prev;
    int          m_prev_ph;

    task automatic model_idle();
        m_run = 0; m_sum_p = 0; m_sum_ph = 0; m_n = 0; m_miss = 0; m_have_prev = 0;
    endtask

    // Called at each driven reference rise (pin driven in cycle c).
    task automatic model_rise(input int unsigned c, input int ph, input bit present);
        int p, s_ph, ap, aph, d;
        res_t r;
        if (m_run) begin
            p = int'(c - m_last_rise);
            s_ph = m_pend_present ? m_pend_ph : p;
            if (!m_pend_present) m_miss = 1;
            m_sum_p += p; m_sum_ph += s_ph; m_n++;
            if (m_n == NAVG) begin
                ap  = m_sum_p / NAVG;
                aph = m_sum_ph / NAVG;
                d   = aph - m_prev_ph;
                if (d < 0) d = -d;
                r.period = ap;
                r.phase  = aph;
                r.lock   = m_have_prev && (d <= TOL) && !m_miss;
                r.cyc    = c + 3;  // two sync flops plus the result register
                exp_q.push_back(r);
                exp_deg_q.push_back((aph >= ap) ? 359 : (aph * 360) / ap);
                m_prev_ph = aph; m_have_prev = 1;
                m_sum_p = 0; m_sum_ph = 0; m_n = 0; m_miss = 0;
            end
        end
        m_run = 1; m_last_rise = c; m_pend_ph = ph; m_pend_present = present;
    endtask

    // One reference period: ref high for the first half, pll high from
    // offset ph (if present), always low in the final cycle.
    task automatic run_period(input int per, input int ph, input bit present);
        for (int i = 0; i < per; i++) begin
            @(negedge clk_50);
            if (i == 0) model_rise(cyc, ph, present);
            if (i == 2) g_ns_pre = nosig;
            if (i == 3) g_ns_post = nosig;
            ref_in = (i < per / 2);
            pll_in = present && (i >= ph) && (i < ph + per / 2) && (i < per - 1);
        end
    endtask

    task automatic do_reset();
        @(negedge clk_50);
        rst = 1; ref_in = 0; pll_in = 0;
        repeat (3) @(negedge clk_50);
        rst = 0;
        model_idle();
        got_q.delete(); exp_q.delete(); deg_q.delete(); exp_deg_q.delete();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        repeat (2) @(negedge clk_50);
        n_checks++; if (period !== 0) $display("FAIL reset_period got %0d want 0", period); else n_pass++;
        n_checks++; if (phase !== 0) $display("FAIL reset_phase got %0d want 0", phase); else n_pass++;
        n_checks++; if (meas_valid !== 0) $display("FAIL reset_meas_valid got %0b want 0", meas_valid); else n_pass++;
        n_checks++; if (nosig !== 1) $display("FAIL reset_nosig got %0b want 1", nosig); else n_pass++;
        n_checks++; if (lock !== 0) $display("FAIL reset_lock got %0b want 0", lock); else n_pass++;
        n_checks++; if (phase_deg !== 0) $display("FAIL reset_phase_deg got %0d want 0", phase_deg); else n_pass++;
        n_checks++; if (deg_valid !== 0) $display("FAIL reset_deg_valid got %0b want 0", deg_valid); else n_pass++;
    endtask

    task automatic test_steady_lock();
        do_reset();
        for (int i = 0; i < 9; i++) run_period(200, 50, 1);
        n_checks++;
        if (got_q.size() != exp_q.size()) $display("FAIL steady_count got %0d want %0d", got_q.size(), exp_q.size());
        else n_pass++;
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            n_checks++;
            if (got_q[i] !== exp_q[i])
                $display("FAIL steady_result%0d got p=%0d ph=%0d lk=%0b cyc=%0d want p=%0d ph=%0d lk=%0b cyc=%0d", i,
                         got_q[i].period, got_q[i].phase, got_q[i].lock, got_q[i].cyc,
                         exp_q[i].period, exp_q[i].phase, exp_q[i].lock, exp_q[i].cyc);
            else n_pass++;
        end
        if (got_q.size() >= 2) begin
            n_checks++;
            if (got_q[0].period != 200 || got_q[0].phase != 50 || got_q[0].lock != 0)
                $display("FAIL steady_first got p=%0d ph=%0d lk=%0b want p=200 ph=50 lk=0",
                         got_q[0].period, got_q[0].phase, got_q[0].lock);
            else n_pass++;
            n_checks++;
            if (got_q[1].lock != 1) $display("FAIL steady_lock2 got %0b want 1", got_q[1].lock);
            else n_pass++;
        end
`ifdef PLL_PHASE_METER_DEG_EN
        n_checks++;
        if (deg_q.size() != 2 || deg_q[0] != 90 || deg_q[1] != 90)
            $display("FAIL steady_deg got n=%0d first=%0d want n=2 first=90", deg_q.size(),
                     (deg_q.size() > 0) ? deg_q[0] : -1);
        else n_pass++;
`endif
    endtask

    task automatic test_timeout();
        int unsigned tgt;
        got_q.delete(); exp_q.delete();
        tgt = m_last_rise + 2 + TIMEOUT;
        while (cyc < tgt) @(negedge clk_50);
        n_checks++; if (nosig !== 0) $display("FAIL timeout_early_nosig got %0b want 0", nosig); else n_pass++;
        n_checks++; if (lock !== 1) $display("FAIL timeout_early_lock got %0b want 1", lock); else n_pass++;
        @(negedge clk_50);
        n_checks++; if (nosig !== 1) $display("FAIL timeout_nosig got %0b want 1", nosig); else n_pass++;
        n_checks++; if (lock !== 0) $display("FAIL timeout_lock got %0b want 0", lock); else n_pass++;
        n_checks++;
        if (period !== 200 || phase !== 50) $display("FAIL timeout_hold got p=%0d ph=%0d want p=200 ph=50", period, phase);
        else n_pass++;
        model_idle();
        run_period(200, 50, 1);
        n_checks++;
        if (g_ns_pre !== 1 || g_ns_post !== 0)
            $display("FAIL timeout_restart_nosig got pre=%0b post=%0b want pre=1 post=0", g_ns_pre, g_ns_post);
        else n_pass++;
        for (int i = 0; i < 4; i++) run_period(200, 50, 1);
        n_checks++;
        if (got_q.size() != 1 || exp_q.size() != 1 || got_q[0] !== exp_q[0])
            $display("FAIL timeout_restart_result got n=%0d want n=%0d", got_q.size(), exp_q.size());
        else n_pass++;
    endtask

    task automatic test_simultaneous();
        do_reset();
        for (int i = 0; i < 9; i++) run_period(100, 0, 1);
        n_checks++;
        if (got_q.size() != exp_q.size()) $display("FAIL simul_count got %0d want %0d", got_q.size(), exp_q.size());
        else n_pass++;
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            n_checks++;
            if (got_q[i] !== exp_q[i])
                $display("FAIL simul_result%0d got p=%0d ph=%0d lk=%0b want p=%0d ph=%0d lk=%0b", i,
                         got_q[i].period, got_q[i].phase, got_q[i].lock,
                         exp_q[i].period, exp_q[i].phase, exp_q[i].lock);
            else n_pass++;
        end
        if (got_q.size() >= 2) begin
            n_checks++;
            if (got_q[1].period != 100 || got_q[1].phase != 0 || got_q[1].lock != 1)
                $display("FAIL simul_second got p=%0d ph=%0d lk=%0b want p=100 ph=0 lk=1",
                         got_q[1].period, got_q[1].phase, got_q[1].lock);
            else n_pass++;
        end
    endtask

    task automatic test_missing_pll();
        do_reset();
        for (int i = 0; i < 9; i++) run_period(100, 0, 0);
        n_checks++;
        if (got_q.size() != exp_q.size()) $display("FAIL miss_count got %0d want %0d", got_q.size(), exp_q.size());
        else n_pass++;
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            n_checks++;
            if (got_q[i] !== exp_q[i] || got_q[i].phase != 100 || got_q[i].lock != 0)
                $display("FAIL miss_result%0d got p=%0d ph=%0d lk=%0b want p=%0d ph=100 lk=0", i,
                         got_q[i].period, got_q[i].phase, got_q[i].lock, exp_q[i].period);
            else n_pass++;
        end
`ifdef PLL_PHASE_METER_DEG_EN
        n_checks++;
        if (deg_q.size() != 2 || deg_q[0] != 359 || deg_q[1] != 359)
            $display("FAIL miss_deg got n=%0d first=%0d want n=2 first=359", deg_q.size(),
                     (deg_q.size() > 0) ? deg_q[0] : -1);
        else n_pass++;
`endif
    endtask

    task automatic test_jitter();
        do_reset();
        for (int i = 0; i < 8; i++) run_period(200, (i % 2 == 0) ? 50 : 60, 1);
        for (int i = 0; i < 9; i++) run_period(200, 70, 1);
        n_checks++;
        if (got_q.size() != exp_q.size()) $display("FAIL jitter_count got %0d want %0d", got_q.size(), exp_q.size());
        else n_pass++;
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            n_checks++;
            if (got_q[i] !== exp_q[i])
                $display("FAIL jitter_result%0d got ph=%0d lk=%0b cyc=%0d want ph=%0d lk=%0b cyc=%0d", i,
                         got_q[i].phase, got_q[i].lock, got_q[i].cyc,
                         exp_q[i].phase, exp_q[i].lock, exp_q[i].cyc);
            else n_pass++;
        end
        if (got_q.size() >= 4) begin
            n_checks++;
            if (got_q[1].phase != 55 || got_q[1].lock != 1 || got_q[2].phase != 70 || got_q[2].lock != 0)
                $display("FAIL jitter_step got ph1=%0d lk1=%0b ph2=%0d lk2=%0b want 55 1 70 0",
                         got_q[1].phase, got_q[1].lock, got_q[2].phase, got_q[2].lock);
            else n_pass++;
        end
    endtask

    // Continues from the locked jitter state so reset has values to clear.
    task automatic test_reset_mid();
        run_period(100, 30, 1);
        run_period(100, 30, 1);
        @(negedge clk_50);
        rst = 1;
        @(negedge clk_50);
        n_checks++;
        if (period !== 0 || phase !== 0 || meas_valid !== 0 || lock !== 0 || phase_deg !== 0 || deg_valid !== 0)
            $display("FAIL rstmid_outputs got p=%0d ph=%0d mv=%0b lk=%0b deg=%0d dv=%0b want all 0",
                     period, phase, meas_valid, lock, phase_deg, deg_valid);
        else n_pass++;
        n_checks++; if (nosig !== 1) $display("FAIL rstmid_nosig got %0b want 1", nosig); else n_pass++;
        rst = 0;
        model_idle();
        got_q.delete(); exp_q.delete();
        for (int i = 0; i < 4; i++) run_period(120, 40, 1);
        n_checks++;
        if (got_q.size() != 0) $display("FAIL rstmid_early got %0d results want 0", got_q.size());
        else n_pass++;
        run_period(120, 40, 1);
        n_checks++;
        if (got_q.size() != 1 || exp_q.size() != 1 || got_q[0] !== exp_q[0])
            $display("FAIL rstmid_result got n=%0d want n=%0d", got_q.size(), exp_q.size());
        else n_pass++;
    endtask

    task automatic test_random();
        int per, ph;
        bit present, steady_mode;
        do_reset();
        for (int w = 0; w < 6; w++) begin
            steady_mode = ($urandom_range(0, 1) == 1);
            for (int k = 0; k < NAVG; k++) begin
                per = $urandom_range(80, 300);
                if (steady_mode) begin
                    ph = 40 + $urandom_range(0, 6);
                    present = 1;
                end else begin
                    ph = $urandom_range(0, per - 2);
                    present = ($urandom_range(0, 9) != 0);
                end
                run_period(per, ph, present);
            end
        end
        run_period(100, 10, 1);
        n_checks++;
        if (got_q.size() != exp_q.size()) $display("FAIL random_count got %0d want %0d", got_q.size(), exp_q.size());
        else n_pass++;
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            n_checks++;
            if (got_q[i] !== exp_q[i])
                $display("FAIL random_result%0d got p=%0d ph=%0d lk=%0b cyc=%0d want p=%0d ph=%0d lk=%0b cyc=%0d", i,
                         got_q[i].period, got_q[i].phase, got_q[i].lock, got_q[i].cyc,
                         exp_q[i].period, exp_q[i].phase, exp_q[i].lock, exp_q[i].cyc);
            else n_pass++;
        end
        repeat (40) @(negedge clk_50);
`ifdef PLL_PHASE_METER_DEG_EN
        n_checks++;
        if (deg_q.size() != exp_deg_q.size()) $display("FAIL random_deg_count got %0d want %0d", deg_q.size(), exp_deg_q.size());
        else n_pass++;
        for (int i = 0; i < deg_q.size() && i < exp_deg_q.size(); i++) begin
            n_checks++;
            if (deg_q[i] != exp_deg_q[i]) $display("FAIL random_deg%0d got %0d want %0d", i, deg_q[i], exp_deg_q[i]);
            else n_pass++;
        end
`else
        n_checks++;
        if (deg_q.size() != 0 || phase_deg !== 0)
            $display("FAIL random_deg_off got n=%0d deg=%0d want n=0 deg=0", deg_q.size(), phase_deg);
        else n_pass++;
`endif
    endtask

    initial begin
        model_idle();
        m_prev_ph = 0;
        test_reset();
        test_steady_lock();
        test_timeout();
        test_simultaneous();
        test_missing_pll();
        test_jitter();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
